// File: rtl/counter_nbit_updown.sv
// Loadable up/down counter with optional modulus (MAX_VAL < 2**WIDTH), wrap or saturate
// behaviour, combinational terminal-count carry for ripple-enable cascading, and a sticky
// overflow flag that records any wrap since the last reset or load.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset (count and ovf to 0)
//   en_i     count enable / carry-in from a lower stage
//   load_i   parallel load of in_i (clamped to MAX_VAL), overrides en_i
//   up_i     1 = increment, 0 = decrement
//   sat_i    1 = saturate at the terminal value, 0 = wrap modulo MAX_VAL+1
//   in_i     load value
//   count_o  registered count, always within 0..MAX_VAL
//   co_o     combinational terminal-count / carry-out
//   ovf_o    registered sticky wrap flag
module counter_nbit_updown #(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] count_o,
  output logic             co_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero;
  logic [WIDTH-1:0] load_val;

  assign at_max  = (count_q == MAX_VAL);
  assign at_zero = (count_q == '0);

  // Out-of-range load values clamp so the count never leaves 0..MAX_VAL.
  assign load_val = (in_i > MAX_VAL) ? MAX_VAL : in_i;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (load_i) begin
      count_d = load_val;
      ovf_d   = 1'b0;
    end else if (en_i) begin
      if (up_i) begin
        if (!at_max) begin
          count_d = count_q + 1'b1;
        end else if (!sat_i) begin
          count_d = '0;
          ovf_d   = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - 1'b1;
        end else if (!sat_i) begin
          count_d = MAX_VAL;
          ovf_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Carry is raised in saturate mode too, and suppressed on load so a downstream stage does
  // not advance while this stage is being overwritten.
  assign co_o    = en_i & ~load_i & ((up_i & at_max) | (~up_i & at_zero));
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_counter_nbit_updown.sv
module tb_counter_nbit_updown;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0, sat = 1'b0;
  logic [3:0] in_v = 4'd0;
  logic       cas_rst = 1'b0;

  logic [3:0] cnt15, cnt9, lo_cnt, hi_cnt;
  logic       co15, co9, lo_co, hi_co, ovf15, ovf9, lo_ovf, hi_ovf;

  counter_nbit_updown #(.WIDTH(4)) u_d15 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .up_i(up), .sat_i(sat),
    .in_i(in_v), .count_o(cnt15), .co_o(co15), .ovf_o(ovf15)
  );

  counter_nbit_updown #(.WIDTH(4), .MAX_VAL(4'd9)) u_d9 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .up_i(up), .sat_i(sat),
    .in_i(in_v), .count_o(cnt9), .co_o(co9), .ovf_o(ovf9)
  );

  counter_nbit_updown #(.WIDTH(4)) u_lo (
    .clk_i(clk), .rst_i(cas_rst), .en_i(1'b1), .load_i(1'b0), .up_i(1'b1), .sat_i(1'b0),
    .in_i(4'd0), .count_o(lo_cnt), .co_o(lo_co), .ovf_o(lo_ovf)
  );

  counter_nbit_updown #(.WIDTH(4)) u_hi (
    .clk_i(clk), .rst_i(cas_rst), .en_i(lo_co), .load_i(1'b0), .up_i(1'b1), .sat_i(1'b0),
    .in_i(4'd0), .count_o(hi_cnt), .co_o(hi_co), .ovf_o(hi_ovf)
  );

  typedef struct {
    int c15; int c9; bit o15; bit o9; int cas; int tag;
  } st_t;
  typedef struct {
    bit co15; bit co9; int tag;
  } co_t;

  st_t st_q[$];
  co_t co_q[$];

  int checks = 0;
  int errors = 0;
  int tag    = 0;

  // Reference state: plain integers, modular arithmetic over 0..max.
  int mcnt[2];
  bit movf[2];
  int mmax[2];
  int mcas;

  function automatic bit model_step(int i, bit r, bit l, bit e, bit u, bit s, int v);
    int  m;
    bit  c;
    m = mmax[i];
    c = e && !l && ((u && mcnt[i] == m) || (!u && mcnt[i] == 0));
    if (r) begin
      mcnt[i] = 0;
      movf[i] = 0;
    end else if (l) begin
      mcnt[i] = (v > m) ? m : v;
      movf[i] = 0;
    end else if (e) begin
      if (u) begin
        if (mcnt[i] == m && s) mcnt[i] = m;
        else begin
          if (mcnt[i] == m) movf[i] = 1;
          mcnt[i] = (mcnt[i] + 1) % (m + 1);
        end
      end else begin
        if (mcnt[i] == 0 && s) mcnt[i] = 0;
        else begin
          if (mcnt[i] == 0) movf[i] = 1;
          mcnt[i] = (mcnt[i] + m) % (m + 1);
        end
      end
    end
    return c;
  endfunction

  task automatic chk(string name, int t, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the expected responses.
  task automatic step(bit r, bit l, bit e, bit u, bit s, int v, bit cr = 1'b0);
    co_t ce;
    st_t se;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; sat = s; in_v = v[3:0]; cas_rst = cr;
    tag++;
    ce.tag  = tag;
    ce.co15 = model_step(0, r, l, e, u, s, v);
    ce.co9  = model_step(1, r, l, e, u, s, v);
    mcas    = cr ? 0 : (mcas + 1) % 256;
    se.tag  = tag;
    se.c15  = mcnt[0]; se.o15 = movf[0];
    se.c9   = mcnt[1]; se.o9  = movf[1];
    se.cas  = mcas;
    co_q.push_back(ce);
    st_q.push_back(se);
  endtask

  // Monitor: co is checked mid-cycle after inputs settle, state just after the edge.
  initial begin
    co_t ce;
    st_t se;
    forever begin
      @(negedge clk);
      #3;
      if (co_q.size() > 0) begin
        ce = co_q.pop_front();
        chk("co15", ce.tag, {31'd0, co15}, {31'd0, ce.co15});
        chk("co9", ce.tag, {31'd0, co9}, {31'd0, ce.co9});
      end
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        se = st_q.pop_front();
        chk("count15", se.tag, {28'd0, cnt15}, se.c15);
        chk("ovf15", se.tag, {31'd0, ovf15}, {31'd0, se.o15});
        chk("count9", se.tag, {28'd0, cnt9}, se.c9);
        chk("ovf9", se.tag, {31'd0, ovf9}, {31'd0, se.o9});
        chk("cascade", se.tag, {24'd0, hi_cnt, lo_cnt}, se.cas);
      end
    end
  end

  initial begin
    mmax[0] = 15; mmax[1] = 9;
    mcnt[0] = 0;  mcnt[1] = 0;
    movf[0] = 0;  movf[1] = 0;
    mcas    = 0;

    // Reset, then up-count with wrap through the terminal value.
    step(1, 0, 0, 1, 0, 0, 1);
    repeat (17) step(0, 0, 1, 1, 0, 0);

    // Down wrap from a loaded value, then a clamped load.
    step(0, 1, 0, 0, 0, 3);
    repeat (6) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 12);

    // Saturate up, then saturate down to zero.
    step(0, 1, 0, 0, 0, 8);
    repeat (4) step(0, 0, 1, 1, 1, 0);
    repeat (11) step(0, 0, 1, 0, 1, 0);

    // Simultaneous events.
    step(0, 1, 0, 0, 0, 5);
    step(0, 1, 1, 1, 0, 2);
    step(0, 1, 0, 0, 0, 7);
    step(1, 1, 1, 1, 0, 3);
    step(0, 1, 0, 0, 0, 15);
    repeat (2) step(0, 0, 0, 1, 0, 0);

    // Reset mid-count while enabled, then resume.
    repeat (6) step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 1, 1, 0, 0);

    // Randomized operation.
    repeat (400) begin
      step(($urandom_range(31) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
           $urandom_range(1), $urandom_range(1), $urandom_range(15));
    end

    @(negedge clk);
    rst = 0; load = 0; en = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (st_q.size() != 0 || co_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", st_q.size(), co_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_nbit_updown.md
# counter_nbit_updown

Parametrised loadable up/down counter with an optional modulus below 2^WIDTH, wrap or saturate mode, a combinational terminal-count carry for cascading and a sticky overflow flag. It generalises the fixed 4-bit load/enable counter used in the datapath. Counters can be chained through `co` → `en` to build wider counters, or used as modulo-N sequencers and loop counters in the controller.

## Interface
- WIDTH, 4, counter width in bits (≥ 2)
- MAX_VAL, 2**WIDTH-1, terminal count for up-counting; count range is 0..MAX_VAL (must be ≤ 2**WIDTH-1)
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, synchronous and active-high
- en  input  1  count enable (carry-in when cascaded)
- load  input  1  parallel load of `in`
- up  input  1  direction: 1 = increment, 0 = decrement
- sat  input  1  mode: 1 = saturate at terminal, 0 = wrap
- in  input  WIDTH  load value
- count  output  WIDTH  registered counter value
- co  output  1  combinational terminal-count / carry-out
- ovf  output  1  registered sticky wrap flag

## Operation
- Priority at each rising clk: rst > load > en. With none active, count holds.
- rst: count ← 0, ovf ← 0.
- load: count ← min(in, MAX_VAL). Out-of-range load values clamp to MAX_VAL. ovf ← 0. en, up and sat are ignored that cycle.
- en, up=1:
  - count < MAX_VAL → count + 1.
  - count == MAX_VAL and sat=0 → 0, ovf ← 1.
  - count == MAX_VAL and sat=1 → hold at MAX_VAL, ovf unchanged.
- en, up=0:
  - count > 0 → count − 1.
  - count == 0 and sat=0 → MAX_VAL, ovf ← 1.
  - count == 0 and sat=1 → hold at 0.
- co = en & ~load & ((up & count==MAX_VAL) | (~up & count==0)).
  - Asserted in both sat modes, so cascading stays correct in wrap mode.
  - Purely combinational from current inputs and count; no dependence on rst.
- ovf: set only by an actual wrap. Cleared only by rst or load. Saturation never sets it.
- Arithmetic is unsigned and modulo (MAX_VAL+1). count never leaves 0..MAX_VAL, including after a load.
- Changing up or sat mid-count takes effect on the next enabled edge. The counter keeps no direction state.

## Timing
- Reset values: count = 0, ovf = 0. co = 0 while en=0.
- Latency: one clock from en/load/rst sampled high to the new count. ovf updates on the same edge as the wrap.
- co is valid in the same cycle en is high with count at terminal. It is intended to drive the next stage's en, giving a single-clock ripple-enable cascade.
- rst asserted mid-count overrides a simultaneous load or en. The counter restarts from 0 on the following enabled edge.
- load together with en in the same cycle: the load wins and no count step occurs. co is forced 0 that cycle, so downstream stages do not advance.
- No multicycle paths. The co path (comparator plus AND) is the critical combinational output.

## Test plan
- Reset/up wrap (WIDTH=4, default MAX_VAL=15): rst 1 cycle, then en=1, up=1, sat=0 for 17 cycles.
  - count 0..15, then 0, 1.
  - co high only in the cycle count=15.
  - ovf rises on the edge 15→0 and stays 1.
- Down wrap and modulus (MAX_VAL=9): load in=3, then en=1, up=0, sat=0.
  - count 3, 2, 1, 0, 9, 8.
  - co high at count=0; ovf set on 0→9.
  - load in=12 → count=9 (clamp) and ovf=0.
- Saturate (MAX_VAL=9):
  - load 8, en=1, up=1, sat=1 for 4 cycles → count 8, 9, 9, 9; co high while at 9; ovf stays 0.
  - Then up=0 for 11 cycles → count reaches 0 and holds at 0.
- Simultaneous events:
  - count=5, load=1, in=2, en=1 → next count=2 and co=0 that cycle.
  - count=7, rst=1, load=1 → next count=0.
  - en=0 with count=15, up=1 → co=0 and count holds.
- Cascade: two WIDTH=4 instances, low.co → high.en, low.en=1, up=1, run 300 cycles.
  - The concatenated value equals a cycle counter mod 256.
  - The high stage increments only on edges where low=15.
- Reset mid-operation: count up to 6, assert rst for one cycle while en=1.
  - count=0 and ovf=0 on the next edge.
  - Counting resumes 1, 2, … once rst is released.
